grayscaler: RTL

GRAYSCALER -- requirements
Module: grayscaler

---
 rtl/grayscaler.sv | 137 +++++++++++++
 1 files changed

// File: rtl/grayscaler.sv
// RGB byte stream to 8-bit grayscale converter with a 2-entry output FIFO and frame FSM.
// Build option: define GRAYSCALER_ROUND_EN to add +128 rounding before the >>8 (default truncates).
module grayscaler #(
  parameter int N = 5,
  parameter int M = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       in_valid,
  output logic       pause,
  output logic [7:0] gray_out,
  output logic       gray_valid,
  input  logic       gray_ready,
  output logic       busy,
  output logic       done
);

  localparam int PIX = N * M;
  localparam int CW  = $clog2(PIX + 1);
`ifdef GRAYSCALER_ROUND_EN
  localparam logic [15:0] ROUND = 16'd128;
`else
  localparam logic [15:0] ROUND = 16'd0;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [1:0]    phase_reg, phase_next;
  logic [7:0]    r_reg, r_next, g_reg, g_next;
  logic [CW-1:0] pix_reg, pix_next;
  logic [1:0]    count_reg, count_next;
  logic          rd_ptr_reg, rd_ptr_next, wr_ptr_reg, wr_ptr_next;
  logic [7:0]    mem [0:1];

  logic          accept, push, pop;
  logic [15:0]   acc;
  logic [7:0]    gray;

  // pause depends only on registered state, so upstream sees no input-to-output path
  assign pause      = (count_reg == 2'd2) || (state_reg == DRAIN);
  assign accept     = (state_reg == RUN) && in_valid && !pause;
  assign push       = accept && (phase_reg == 2'd2);
  assign gray_valid = (count_reg != 2'd0);
  assign pop        = gray_valid && gray_ready;
  assign gray_out   = gray_valid ? mem[rd_ptr_reg] : 8'h00;
  assign busy       = (state_reg == RUN) || (state_reg == DRAIN);
  assign done       = (state_reg == DONE);

  // B byte comes straight from data_in so the pixel is pushed on the edge it is accepted
  assign acc  = 16'd77 * {8'd0, r_reg} + 16'd150 * {8'd0, g_reg}
              + 16'd29 * {8'd0, data_in} + ROUND;
  assign gray = 8'(acc >> 8);

  always_comb begin
    state_next  = state_reg;
    phase_next  = phase_reg;
    r_next      = r_reg;
    g_next      = g_reg;
    pix_next    = pix_reg;
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;

    if (push && !pop)
      count_next = count_reg + 2'd1;
    else if (!push && pop)
      count_next = count_reg - 2'd1;
    if (push)
      wr_ptr_next = ~wr_ptr_reg;
    if (pop)
      rd_ptr_next = ~rd_ptr_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          phase_next  = 2'd0;
          pix_next    = '0;
          count_next  = 2'd0;
          rd_ptr_next = 1'b0;
          wr_ptr_next = 1'b0;
          state_next  = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          case (phase_reg)
            2'd0:    begin r_next = data_in; phase_next = 2'd1; end
            2'd1:    begin g_next = data_in; phase_next = 2'd2; end
            default: phase_next = 2'd0;
          endcase
        end
        if (push) begin
          pix_next = pix_reg + CW'(1);
          if (pix_reg == CW'(PIX - 1))
            state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (count_reg == 2'd0)
          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      phase_reg  <= 2'd0;
      r_reg      <= 8'd0;
      g_reg      <= 8'd0;
      pix_reg    <= '0;
      count_reg  <= 2'd0;
      rd_ptr_reg <= 1'b0;
      wr_ptr_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      phase_reg  <= phase_next;
      r_reg      <= r_next;
      g_reg      <= g_next;
      pix_reg    <= pix_next;
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
    end
  end

  // FIFO storage needs no reset: gray_out is masked whenever count is zero
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= gray;
  end

endmodule
